// File: rtl/fib_responder_if.sv
// Call handshake between an initiator and the Fibonacci responder.
interface fib_responder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             read;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             write;
  logic             busy;

  modport master (
    output read,
    output a,
    input  b,
    input  write,
    input  busy
  );

  modport slave (
    input  read,
    input  a,
    output b,
    output write,
    output busy
  );
endinterface

// File: rtl/fib_responder.sv
// Iterative Fibonacci responder: accepts n on a read strobe and returns fib(n)
// with a single-cycle write strobe n+1 cycles later. A read while running
// restarts the call; the aborted call never produces a write.
module fib_responder #(
  parameter int unsigned WIDTH = 16
) (
  input logic           clk,
  input logic           nrst,
  fib_responder_if.slave bus
);

  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  logic             state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             write_q, write_d;

  // Next-state: load on read (read always wins), step the pair, or complete.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    write_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.read) begin
          x_d     = '0;
          y_d     = {{(WIDTH-1){1'b0}}, 1'b1};
          cnt_d   = bus.a;
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.read) begin
          // Restart; also suppresses a completion due on this edge.
          x_d   = '0;
          y_d   = {{(WIDTH-1){1'b0}}, 1'b1};
          cnt_d = bus.a;
        end else if (cnt_q != '0) begin
          x_d   = y_q;
          y_d   = x_q + y_q;  // wraps mod 2^WIDTH
          cnt_d = cnt_q - 1'b1;
        end else begin
          b_d     = x_q;
          write_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any call in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      b_q     <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      write_q <= write_d;
    end
  end

  // Outputs come straight from flops.
  assign bus.b     = b_q;
  assign bus.write = write_q;
  assign bus.busy  = (state_q == StRun);

endmodule

// File: tb/tb_fib_responder.sv
// Self-checking bench for fib_responder: a call-level model predicts
// b/write/busy every cycle; directed calls pin the model with literals.
module tb_fib_responder;

  logic clk;
  logic nrst;

  fib_responder_if #(.WIDTH(16)) bus ();

  fib_responder #(.WIDTH(16)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] fib(input int n);
    logic [15:0] p, q, t;
    p = 16'd0;
    q = 16'd1;
    for (int i = 0; i < n; i++) begin
      t = p + q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Call-level model: a call accepted at edge c completes at edge c+n+1.
  int          cyc = 0;
  bit          pend;
  int          due;
  logic [15:0] pval;
  logic [15:0] exp_b;
  logic        exp_write;
  logic        exp_busy;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend      <= 1'b0;
      exp_b     <= 16'd0;
      exp_write <= 1'b0;
      exp_busy  <= 1'b0;
    end else begin
      exp_write <= 1'b0;
      if (bus.read) begin
        pend     <= 1'b1;
        due      <= cyc + int'(bus.a) + 1;
        pval     <= fib(int'(bus.a));
        exp_busy <= 1'b1;
      end else if (pend && cyc == due) begin
        exp_write <= 1'b1;
        exp_b     <= pval;
        pend      <= 1'b0;
        exp_busy  <= 1'b0;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("cyc write", {31'd0, bus.write}, {31'd0, exp_write});
    check("cyc b", {16'd0, bus.b}, {16'd0, exp_b});
    check("cyc busy", {31'd0, bus.busy}, {31'd0, exp_busy});
    if (bus.write === 1'b1) wr_cnt <= wr_cnt + 1;
  end

  // Present a read for one edge; returns at the negedge after the accepting edge.
  task automatic start(input int n);
    bus.read = 1'b1;
    bus.a    = n[15:0];
    @(negedge clk);
    bus.read = 1'b0;
    bus.a    = 16'hFFFF;  // later changes to a must be ignored
  endtask

  // Wait (bounded) for write; check latency from the accepting edge and b.
  task automatic wait_write(input int exp_lat, input logic [15:0] expv, input string name);
    int lat;
    lat = 0;
    while (bus.write !== 1'b1 && lat < exp_lat + 4) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " b"}, {16'd0, bus.b}, {16'd0, expv});
  endtask

  task automatic do_call(input int n, input logic [15:0] expv, input string name);
    start(n);
    wait_write(n + 1, expv, name);
  endtask

  int wr0;

  initial begin
    nrst     = 1'b1;
    bus.read = 1'b0;
    bus.a    = 16'd0;
    #1 nrst = 1'b0;
    #2;
    check("reset b", {16'd0, bus.b}, 32'd0);
    check("reset write", {31'd0, bus.write}, 32'd0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    // Small arguments, back-to-back
    do_call(0, 16'd0, "a0");
    do_call(1, 16'd1, "a1");
    do_call(10, 16'd55, "a10");

    // Range sweep, each call issued in the write cycle of the previous one
    for (int n = 0; n <= 24; n++) do_call(n, fib(n), "sweep");
    check("sweep end", {16'd0, bus.b}, 32'd46368);
    do_call(25, 16'd9489, "wrap25");

    // Restart mid-call
    start(20);
    repeat (2) @(negedge clk);
    wr0 = wr_cnt;
    start(5);
    wait_write(6, 16'd5, "restart");
    repeat (25) @(negedge clk);
    #1 check("restart writes", wr_cnt - wr0, 1);

    // Collision: read on the edge a=7 would complete
    start(7);
    repeat (7) @(negedge clk);
    start(3);
    check("collision write", {31'd0, bus.write}, 32'd0);
    check("collision b", {16'd0, bus.b}, 32'd5);
    wait_write(4, 16'd2, "collision");

    // Reset abort mid-call
    @(negedge clk);
    start(15);
    repeat (4) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("abort b", {16'd0, bus.b}, 32'd0);
    check("abort write", {31'd0, bus.write}, 32'd0);
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    wr0 = wr_cnt;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    do_call(6, 16'd8, "post reset");
    repeat (25) @(negedge clk);
    #1 check("abort writes", wr_cnt - wr0, 1);

    // Back-to-back
    @(negedge clk);
    do_call(4, 16'd3, "b2b first");
    do_call(2, 16'd1, "b2b second");
    @(negedge clk);
    check("b2b pulse", {31'd0, bus.write}, 32'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
